// File: rtl/x65_reset_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and request source indices.
package x65_reset_pkg;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_QUIESCE    = 2'd1,
    ST_HOLD       = 2'd2,
    ST_REL_PERIPH = 2'd3
  } state_t;

  // Request source indices. A lower index has higher priority for last_cause_o.
  localparam int SRC_BTN  = 0;
  localparam int SRC_WDOG = 1;
  localparam int SRC_SW   = 2;
  localparam int SRC_DBG  = 3;

endpackage

// File: rtl/reset_req_edge.sv
// Request front end: masks the sources, registers them, detects rising edges
// and reports the lowest-index (highest-priority) source that produced an edge.
module reset_req_edge #(
  parameter int NSRC  = 4,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   req,
  input  logic [NSRC-1:0]   mask,
  output logic [NSRC-1:0]   edge_bits,
  output logic              trig,
  output logic              level_any,
  output logic [IDX_W-1:0]  idx
);

  logic [NSRC-1:0] masked_s;
  logic [NSRC-1:0] prev_r;

  // Lowest set bit index; index 0 wins over all others.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NSRC-1:0] v);
    lowest_set = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  assign masked_s  = req & mask;
  assign edge_bits = masked_s & ~prev_r;
  assign trig      = |edge_bits;
  assign level_any = |masked_s;
  assign idx       = lowest_set(edge_bits);

  // Previous masked request levels; all-ones at reset so a request held
  // through block reset does not look like a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= '1;
    end else begin
      prev_r <= masked_s;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: collects reset requests, quiesces the CPU, then holds both
// resets and releases the peripheral reset before the CPU reset. Latches the cause.
module reset_sequencer
  import x65_reset_pkg::*;
#(
  parameter int NSRC        = 4,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER_CYC = 8,
  parameter int QTIMEOUT    = 255,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NSRC-1:0]           req_i,
  input  logic [NSRC-1:0]           req_mask_i,
  input  logic                      stop_ack_i,
  input  logic                      cause_clr_i,
  output logic                      stop_req_o,
  output logic                      periph_reset_o,
  output logic                      cpu_reset_o,
  output logic                      cpu_resn_o,
  output logic                      busy_o,
  output logic [NSRC-1:0]           cause_o,
  output logic [$clog2(NSRC)-1:0]   last_cause_o,
  output logic                      por_o
);

  localparam int IDX_W = $clog2(NSRC);
  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0] QTO_LOAD     = CNT_W'(QTIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [NSRC-1:0]   edge_bits_s;
  logic              trig_s, level_any_s;
  logic [IDX_W-1:0]  idx_s;
  logic [NSRC-1:0]   cause_s;
  logic [IDX_W-1:0]  last_s;
  logic              por_s;

  reset_req_edge #(.NSRC(NSRC), .IDX_W(IDX_W)) u_req_edge (
    .clk       (clk),
    .reset     (reset),
    .req       (req_i),
    .mask      (req_mask_i),
    .edge_bits (edge_bits_s),
    .trig      (trig_s),
    .level_any (level_any_s),
    .idx       (idx_s)
  );

  // Next-state and shared down-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (trig_s) begin
          state_s = ST_QUIESCE;
          cnt_s   = QTO_LOAD;
        end else begin
          cnt_s   = cnt_r;
        end
      end
      ST_QUIESCE: begin
        if (stop_ack_i || (cnt_r == '0)) begin
          state_s = ST_HOLD;
          cnt_s   = HOLD_LOAD;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (trig_s) begin
          cnt_s = HOLD_LOAD;
        end else if (cnt_r != '0) begin
          cnt_s = cnt_r - CNT_ONE;
        end else if (!level_any_s) begin
          state_s = ST_REL_PERIPH;
          cnt_s   = STAGGER_LOAD;
        end else begin
          cnt_s   = cnt_r;  // level request parks the sequence here
        end
      end
      ST_REL_PERIPH: begin
        if (trig_s) begin
          state_s = ST_HOLD;
          cnt_s   = HOLD_LOAD;
        end else if (cnt_r == '0) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = ST_HOLD;
        cnt_s   = HOLD_LOAD;
      end
    endcase
  end

  // Sticky cause capture; a trigger overrides a simultaneous clear.
  always_comb begin
    cause_s = cause_o;
    last_s  = last_cause_o;
    por_s   = por_o;
    if (trig_s) begin
      cause_s = (cause_clr_i ? '0 : cause_o) | edge_bits_s;
      last_s  = idx_s;
      por_s   = 1'b0;
    end else if (cause_clr_i) begin
      cause_s = '0;
      por_s   = 1'b0;
    end else begin
      cause_s = cause_o;
    end
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_HOLD;
      cnt_r          <= HOLD_LOAD;
      stop_req_o     <= 1'b0;
      periph_reset_o <= 1'b1;
      cpu_reset_o    <= 1'b1;
      cpu_resn_o     <= 1'b0;
      busy_o         <= 1'b1;
      cause_o        <= '0;
      last_cause_o   <= '0;
      por_o          <= 1'b1;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      stop_req_o     <= (state_s == ST_QUIESCE);
      periph_reset_o <= (state_s == ST_HOLD);
      cpu_reset_o    <= (state_s == ST_HOLD) || (state_s == ST_REL_PERIPH);
      cpu_resn_o     <= !((state_s == ST_HOLD) || (state_s == ST_REL_PERIPH));
      busy_o         <= (state_s != ST_IDLE);
      cause_o        <= cause_s;
      last_cause_o   <= last_s;
      por_o          <= por_s;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_i, req_mask_i;
  logic       stop_ack_i, cause_clr_i;
  logic       stop_req_o, periph_reset_o, cpu_reset_o, cpu_resn_o, busy_o, por_o;
  logic [3:0] cause_o;
  logic [1:0] last_cause_o;

  int n_checks = 0;
  int n_pass = 0;
  int n_stop, n_periph, n_cpu;
  int n_resn_bad = 0;

  reset_sequencer dut (
    .clk(clk), .reset(reset), .req_i(req_i), .req_mask_i(req_mask_i),
    .stop_ack_i(stop_ack_i), .cause_clr_i(cause_clr_i),
    .stop_req_o(stop_req_o), .periph_reset_o(periph_reset_o), .cpu_reset_o(cpu_reset_o),
    .cpu_resn_o(cpu_resn_o), .busy_o(busy_o), .cause_o(cause_o),
    .last_cause_o(last_cause_o), .por_o(por_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic zero_counts();
    n_stop = 0; n_periph = 0; n_cpu = 0;
  endtask

  // Advance to the next falling edge and tally which outputs are high.
  task automatic cycle();
    @(negedge clk);
    if (stop_req_o === 1'b1) n_stop++;
    if (periph_reset_o === 1'b1) n_periph++;
    if (cpu_reset_o === 1'b1) n_cpu++;
    if (cpu_resn_o !== ~cpu_reset_o) n_resn_bad++;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int k = 0;
    while (busy_o === 1'b1 && k < bound) begin
      cycle();
      k++;
    end
    check({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_i = 4'b0000; req_mask_i = 4'b1111;
    stop_ack_i = 1'b0; cause_clr_i = 1'b0;

    // 1: block reset, then power-on sequence
    cycle(); cycle();
    zero_counts();
    cycle();
    check("rst_periph", 32'(periph_reset_o), 32'd1);
    check("rst_cpu",    32'(cpu_reset_o),    32'd1);
    check("rst_resn",   32'(cpu_resn_o),     32'd0);
    check("rst_stop",   32'(stop_req_o),     32'd0);
    check("rst_busy",   32'(busy_o),         32'd1);
    check("rst_cause",  32'(cause_o),        32'd0);
    check("rst_last",   32'(last_cause_o),   32'd0);
    check("rst_por",    32'(por_o),          32'd1);
    reset = 1'b0;
    wait_idle(100, "t1");
    check("t1_periph_cyc", n_periph, 32'd16);
    check("t1_cpu_cyc",    n_cpu,    32'd24);
    check("t1_stop_cyc",   n_stop,   32'd0);
    check("t1_por",        32'(por_o),   32'd1);
    check("t1_cause",      32'(cause_o), 32'd0);
    check("t1_idle_outs",  32'({stop_req_o, periph_reset_o, cpu_reset_o, cpu_resn_o}), 32'b0001);

    // 2: SW pulse, stop_ack after 5 cycles of stop_req
    zero_counts();
    req_i = 4'b0100; cycle(); req_i = 4'b0000;
    repeat (4) cycle();
    stop_ack_i = 1'b1; cycle(); stop_ack_i = 1'b0;
    check("t2_hold_entry", 32'(periph_reset_o), 32'd1);
    wait_idle(100, "t2");
    check("t2_stop_cyc",   n_stop,   32'd5);
    check("t2_periph_cyc", n_periph, 32'd16);
    check("t2_cpu_cyc",    n_cpu,    32'd24);
    check("t2_cause",      32'(cause_o),      32'b0100);
    check("t2_last",       32'(last_cause_o), 32'd2);
    check("t2_por",        32'(por_o),        32'd0);

    // 3: watchdog pulse, no stop_ack -> quiesce timeout
    zero_counts();
    req_i = 4'b0010; cycle(); req_i = 4'b0000;
    wait_idle(1000, "t3");
    check("t3_stop_cyc",   n_stop,   32'd256);
    check("t3_periph_cyc", n_periph, 32'd16);
    check("t3_cpu_cyc",    n_cpu,    32'd24);
    check("t3_cause",      32'(cause_o),      32'b0110);
    check("t3_last",       32'(last_cause_o), 32'd1);
    cause_clr_i = 1'b1; cycle(); cause_clr_i = 1'b0;
    check("t3_clr_cause",  32'(cause_o), 32'd0);

    // 4: button held high 100 cycles keeps HOLD
    zero_counts();
    req_i = 4'b0001; cycle();
    stop_ack_i = 1'b1; cycle(); stop_ack_i = 1'b0;
    repeat (98) cycle();
    check("t4_held", 32'(periph_reset_o), 32'd1);
    req_i = 4'b0000;
    wait_idle(100, "t4");
    check("t4_stop_cyc",   n_stop,   32'd1);
    check("t4_periph_cyc", n_periph, 32'd99);
    check("t4_cpu_cyc",    n_cpu,    32'd107);
    check("t4_cause",      32'(cause_o),      32'b0001);
    check("t4_last",       32'(last_cause_o), 32'd0);

    // 5: debug request during REL_PERIPH re-enters HOLD
    zero_counts();
    req_i = 4'b0001; cycle(); req_i = 4'b0000;
    stop_ack_i = 1'b1; cycle(); stop_ack_i = 1'b0;
    repeat (15) cycle();
    cycle(); cycle();
    check("t5_rel_periph", 32'(periph_reset_o), 32'd0);
    check("t5_rel_cpu",    32'(cpu_reset_o),    32'd1);
    req_i = 4'b1000; cycle(); req_i = 4'b0000;
    check("t5_reassert",   32'(periph_reset_o), 32'd1);
    wait_idle(100, "t5");
    check("t5_stop_cyc",   n_stop,   32'd1);
    check("t5_periph_cyc", n_periph, 32'd32);
    check("t5_cpu_cyc",    n_cpu,    32'd42);
    check("t5_cause",      32'(cause_o),      32'b1001);
    check("t5_last",       32'(last_cause_o), 32'd3);

    // 6: masked watchdog + SW together, clear in the same cycle as the trigger
    req_mask_i = 4'b0100;
    req_i = 4'b0110; cause_clr_i = 1'b1; cycle();
    req_i = 4'b0000; cause_clr_i = 1'b0;
    check("t6_cause", 32'(cause_o),      32'b0100);
    check("t6_last",  32'(last_cause_o), 32'd2);
    check("t6_stop",  32'(stop_req_o),   32'd1);
    stop_ack_i = 1'b1; cycle(); stop_ack_i = 1'b0;
    wait_idle(100, "t6");
    cause_clr_i = 1'b1; cycle(); cause_clr_i = 1'b0;
    check("t6_clr_cause", 32'(cause_o), 32'd0);
    check("t6_clr_por",   32'(por_o),   32'd0);

    // 7: request held through block reset is a level, not an edge
    req_mask_i = 4'b1111; req_i = 4'b0001; reset = 1'b1; cycle();
    check("t7_por_set", 32'(por_o), 32'd1);
    zero_counts();
    reset = 1'b0;
    repeat (20) cycle();
    check("t7_level_hold", 32'(periph_reset_o), 32'd1);
    req_i = 4'b0000;
    wait_idle(100, "t7");
    check("t7_stop_cyc",   n_stop,   32'd0);
    check("t7_periph_cyc", n_periph, 32'd20);
    check("t7_cpu_cyc",    n_cpu,    32'd28);
    check("t7_cause",      32'(cause_o), 32'd0);
    cause_clr_i = 1'b1; cycle(); cause_clr_i = 1'b0;
    check("t7_clr_por",    32'(por_o), 32'd0);

    check("resn_inverse", n_resn_bad, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
